// File: rtl/axi_pkg.sv
// Shared AXI address-channel definitions: field widths, master count,
// default-slave index, slave address windows and the arbiter state encoding.
package axi_pkg;

  localparam int AXI_ID_BITS    = 4;
  localparam int AXI_IDS_BITS   = 8;
  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXI_LEN_BITS   = 4;
  localparam int AXI_SIZE_BITS  = 3;
  localparam int AXI_BURST_BITS = 2;

  localparam int         NUM_M   = 3;
  localparam logic [2:0] DEF_SLV = 3'd6;

  localparam logic [AXI_ADDR_BITS-1:0] SLV0_BASE  = 32'h0000_0000;
  localparam logic [AXI_ADDR_BITS-1:0] SLV0_LIMIT = 32'h0000_3FFF;
  localparam logic [AXI_ADDR_BITS-1:0] SLV1_BASE  = 32'h0001_0000;
  localparam logic [AXI_ADDR_BITS-1:0] SLV1_LIMIT = 32'h0001_FFFF;
  localparam logic [AXI_ADDR_BITS-1:0] SLV2_BASE  = 32'h0002_0000;
  localparam logic [AXI_ADDR_BITS-1:0] SLV2_LIMIT = 32'h0002_FFFF;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // One master's address-channel payload, packed in bus order.
  typedef struct packed {
    logic [AXI_ID_BITS-1:0]    id;
    logic [AXI_ADDR_BITS-1:0]  addr;
    logic [AXI_LEN_BITS-1:0]   len;
    logic [AXI_SIZE_BITS-1:0]  size;
    logic [AXI_BURST_BITS-1:0] burst;
  } ax_req_t;

  function automatic logic in_range(input logic [AXI_ADDR_BITS-1:0] a,
                                    input logic [AXI_ADDR_BITS-1:0] base,
                                    input logic [AXI_ADDR_BITS-1:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/addr_map_dec.sv
// Combinational address decoder: maps an address to a slave index, falling
// back to the default slave outside the three mapped windows. Stateless, so
// read and write channels can each instantiate their own copy.
module addr_map_dec #(
  parameter logic [2:0] DEF_SLV = axi_pkg::DEF_SLV
) (
  input  logic [axi_pkg::AXI_ADDR_BITS-1:0] ADDR,
  output logic [2:0]                        slave
);
  import axi_pkg::*;

  // Window lookup; first match wins, windows do not overlap.
  always_comb begin
    slave = DEF_SLV;
    if (in_range(ADDR, SLV0_BASE, SLV0_LIMIT)) begin
      slave = 3'd0;
    end else if (in_range(ADDR, SLV1_BASE, SLV1_LIMIT)) begin
      slave = 3'd1;
    end else if (in_range(ADDR, SLV2_BASE, SLV2_LIMIT)) begin
      slave = 3'd2;
    end
  end

endmodule

// File: rtl/addr_arbiter.sv
// Round-robin arbiter for one AXI address channel (AR or AW). Three masters
// compete; the winner's slave index is decoded and latched at grant time and
// its fields are forwarded to the bus until the selected slave accepts. Each
// channel uses its own instance; nothing is shared between instances.
module addr_arbiter #(
  parameter int         NUM_M   = axi_pkg::NUM_M,
  parameter logic [2:0] DEF_SLV = axi_pkg::DEF_SLV
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [axi_pkg::AXI_ID_BITS-1:0]      AID_M0,
  input  logic [axi_pkg::AXI_ADDR_BITS-1:0]    ADDR_M0,
  input  logic [axi_pkg::AXI_LEN_BITS-1:0]     ALEN_M0,
  input  logic [axi_pkg::AXI_SIZE_BITS-1:0]    ASIZE_M0,
  input  logic [axi_pkg::AXI_BURST_BITS-1:0]   ABURST_M0,
  input  logic                                 AVALID_M0,
  output logic                                 AREADY_M0,
  input  logic [axi_pkg::AXI_ID_BITS-1:0]      AID_M1,
  input  logic [axi_pkg::AXI_ADDR_BITS-1:0]    ADDR_M1,
  input  logic [axi_pkg::AXI_LEN_BITS-1:0]     ALEN_M1,
  input  logic [axi_pkg::AXI_SIZE_BITS-1:0]    ASIZE_M1,
  input  logic [axi_pkg::AXI_BURST_BITS-1:0]   ABURST_M1,
  input  logic                                 AVALID_M1,
  output logic                                 AREADY_M1,
  input  logic [axi_pkg::AXI_ID_BITS-1:0]      AID_M2,
  input  logic [axi_pkg::AXI_ADDR_BITS-1:0]    ADDR_M2,
  input  logic [axi_pkg::AXI_LEN_BITS-1:0]     ALEN_M2,
  input  logic [axi_pkg::AXI_SIZE_BITS-1:0]    ASIZE_M2,
  input  logic [axi_pkg::AXI_BURST_BITS-1:0]   ABURST_M2,
  input  logic                                 AVALID_M2,
  output logic                                 AREADY_M2,
  output logic [axi_pkg::AXI_IDS_BITS-1:0]     AID_BUS,
  output logic [axi_pkg::AXI_ADDR_BITS-1:0]    ADDR_BUS,
  output logic [axi_pkg::AXI_LEN_BITS-1:0]     ALEN_BUS,
  output logic [axi_pkg::AXI_SIZE_BITS-1:0]    ASIZE_BUS,
  output logic [axi_pkg::AXI_BURST_BITS-1:0]   ABURST_BUS,
  output logic                                 AVALID_BUS,
  output logic [2:0]                           slave,
  input  logic                                 AREADY_S0,
  input  logic                                 AREADY_S1,
  input  logic                                 AREADY_S2,
  input  logic                                 AREADY_SD
);
  import axi_pkg::*;

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;
  logic [2:0] slave_q;

  ax_req_t    req [3];
  logic [2:0] avalid;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  ax_req_t    win_req;
  logic [2:0] win_slv;

  ax_req_t    gnt_req;
  logic       gnt_valid;
  logic       sel_rdy;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (int'(i) == NUM_M - 1) ? 2'd0 : i + 2'd1;
  endfunction

  assign req[0] = {AID_M0, ADDR_M0, ALEN_M0, ASIZE_M0, ABURST_M0};
  assign req[1] = {AID_M1, ADDR_M1, ALEN_M1, ASIZE_M1, ABURST_M1};
  assign req[2] = {AID_M2, ADDR_M2, ALEN_M2, ASIZE_M2, ABURST_M2};
  assign avalid = {AVALID_M2, AVALID_M1, AVALID_M0};

  // Pointer advances past the master that just completed its handshake.
  assign rr_ptr_d = next_idx(grant_q);

  // Round-robin search: first valid master at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_M; k++) begin
      if (!win_found && avalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Winner and granted-master payload selection.
  always_comb begin
    case (win_idx)
      2'd1:    win_req = req[1];
      2'd2:    win_req = req[2];
      default: win_req = req[0];
    endcase
    case (grant_q)
      2'd1:    begin gnt_req = req[1]; gnt_valid = AVALID_M1; end
      2'd2:    begin gnt_req = req[2]; gnt_valid = AVALID_M2; end
      default: begin gnt_req = req[0]; gnt_valid = AVALID_M0; end
    endcase
  end

  addr_map_dec #(
    .DEF_SLV (DEF_SLV)
  ) u_dec (
    .ADDR  (win_req.addr),
    .slave (win_slv)
  );

  // Only the latched slave's ready counts; the others are ignored.
  always_comb begin
    case (slave_q)
      3'd0:    sel_rdy = AREADY_S0;
      3'd1:    sel_rdy = AREADY_S1;
      3'd2:    sel_rdy = AREADY_S2;
      default: sel_rdy = AREADY_SD;
    endcase
  end

  // Arbitration FSM: grant from IDLE, return on handshake or on the granted
  // master withdrawing its request (pointer untouched in that case).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      slave_q  <= DEF_SLV;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            slave_q <= win_slv;
            state_q <= ARB_GRANT;
          end
        end
        default: begin
          if (!gnt_valid) begin
            state_q <= ARB_IDLE;
          end else if (sel_rdy) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Bus side: quiet in IDLE, granted master's fields forwarded in GRANT.
  always_comb begin
    AID_BUS    = '0;
    ADDR_BUS   = '0;
    ALEN_BUS   = '0;
    ASIZE_BUS  = '0;
    ABURST_BUS = '0;
    AVALID_BUS = 1'b0;
    slave      = DEF_SLV;
    AREADY_M0  = 1'b0;
    AREADY_M1  = 1'b0;
    AREADY_M2  = 1'b0;
    if (state_q == ARB_GRANT) begin
      AID_BUS    = {2'b00, grant_q, gnt_req.id};
      ADDR_BUS   = gnt_req.addr;
      ALEN_BUS   = gnt_req.len;
      ASIZE_BUS  = gnt_req.size;
      ABURST_BUS = gnt_req.burst;
      AVALID_BUS = gnt_valid;
      slave      = slave_q;
      AREADY_M0  = (grant_q == 2'd0) && sel_rdy;
      AREADY_M1  = (grant_q == 2'd1) && sel_rdy;
      AREADY_M2  = (grant_q == 2'd2) && sel_rdy;
    end
  end

endmodule

// File: doc/addr_arbiter.md
ADDR_ARBITER -- requirements
Module: addr_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_M, 3, number of masters; DEF_SLV, 3'd6, slave index for unmapped addresses.
REQ-002 ACLK  in  1  single clock, all state on rising edge.
REQ-003 ARESETn  in  1  asynchronous active-low reset.
REQ-004 AID_Mx (x=0..2)  in  AXI_ID_BITS (4)  master transaction ID.
REQ-005 ADDR_Mx  in  AXI_ADDR_BITS (32)  master address.
REQ-006 ALEN_Mx / ASIZE_Mx / ABURST_Mx  in  AXI_LEN_BITS (4) / AXI_SIZE_BITS (3) / 2  burst attributes.
REQ-007 AVALID_Mx  in  1  master request valid; AREADY_Mx  out  1  master handshake ready.
REQ-008 AID_BUS  out  AXI_IDS_BITS (8)  {4-bit master index, AID_Mx}.
REQ-009 ADDR_BUS / ALEN_BUS / ASIZE_BUS / ABURST_BUS  out  32/4/3/2  granted master's fields.
REQ-010 AVALID_BUS  out  1  bus request valid toward the slave-side decoder.
REQ-011 slave  out  3  target slave index: 0,1,2 or DEF_SLV.
REQ-012 AREADY_S0 / AREADY_S1 / AREADY_S2 / AREADY_SD  in  1  slave ready and default-slave ready.

Function
REQ-013 FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE: if any AVALID_Mx=1, SHALL select one master by round-robin, register grant index, latched slave index, enter GRANT next cycle; else stay IDLE.
REQ-015 Round-robin: search starts at rr_ptr, ascending mod 3; after handshake with master m, rr_ptr SHALL become (m+1) mod 3.
REQ-016 Address map (decoded from ADDR_Mx of winner, latched at grant): 0x0000_0000-0x0000_3FFF -> 0; 0x0001_0000-0x0001_FFFF -> 1; 0x0002_0000-0x0002_FFFF -> 2; all else -> DEF_SLV.
REQ-017 GRANT: bus outputs SHALL mux granted master's fields combinationally; AVALID_BUS = AVALID of granted master; slave = latched index.
REQ-018 GRANT: AREADY_Mg SHALL equal the ready of the latched slave (AREADY_SD for DEF_SLV); all other AREADY_Mx=0.
REQ-019 Handshake (AVALID_BUS & selected ready) in GRANT SHALL return FSM to IDLE next cycle and update rr_ptr; no new grant in same cycle.
REQ-020 Request-to-AVALID_BUS latency SHALL be exactly 1 cycle; back-to-back grants SHALL be spaced at least 2 cycles (one IDLE cycle).
REQ-021 IDLE: all bus outputs SHALL be 0, slave=DEF_SLV, all AREADY_Mx=0.
REQ-022 Granted master dropping AVALID before handshake (protocol violation) SHALL return FSM to IDLE without rr_ptr update.
REQ-023 Simultaneous requests from all three SHALL be served in rr_ptr order with no master starved beyond 2 other grants.
REQ-024 Ready asserted by a non-selected slave SHALL be ignored.

Reset
REQ-025 ARESETn low SHALL asynchronously force IDLE, rr_ptr=0, grant index=0, latched slave=DEF_SLV; outputs per REQ-021.
REQ-026 Reset mid-GRANT SHALL abort the transaction with no AREADY_Mx pulse; first post-reset grant follows rr_ptr=0.

Structure
REQ-027 Width macros, NUM_M, DEF_SLV, slave base/limit constants and the FSM state enum SHALL reside in shared package axi_pkg.
REQ-028 Address decode SHALL be a sub-module addr_map_dec (ADDR in, 3-bit slave out), purely combinational, reusable by read and write channels.
REQ-029 One instance SHALL serve AR channel and a second the AW channel; no state shared between them.

Verification
REQ-030 M1 only, ADDR=0x0001_0040, AREADY_S1 high -> AVALID_BUS at cycle+1, slave=1, AID_BUS={4'd1,AID_M1}, AREADY_M1 one-cycle pulse.
REQ-031 M0,M1,M2 all valid from reset, slaves always ready -> grant order M0,M1,M2,M0, each 2 cycles apart.
REQ-032 M2 ADDR=0x8000_0000 -> slave=6, AREADY_M2 follows AREADY_SD; AREADY_S0..S2 toggling ignored.
REQ-033 M0 to slave 2, AREADY_S2 low for 5 cycles then high -> bus fields stable 5 cycles, single handshake, M1 request held waiting.
REQ-034 ARESETn low during GRANT to slave 0 -> outputs zero immediately, slave=6, no AREADY_M pulse; after release M0 granted first.
